// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - registered one-hot grant decoder with hold timeout and cooldown.
module grant_decoder #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] enc,
  input  logic       valid,
  output logic       ready,
  input  logic       release_i,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] last_enc,
  output logic [7:0] grant_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state, state_n;
  logic [7:0] grant_n, grant_cnt_n, hold_cnt, hold_cnt_n;
  logic [2:0] last_enc_n;
  logic       timeout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 8'd0;
      hold_cnt  <= 8'd0;
      timeout   <= 1'b0;
      last_enc  <= 3'd0;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      hold_cnt  <= hold_cnt_n;
      timeout   <= timeout_n;
      last_enc  <= last_enc_n;
      grant_cnt <= grant_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    hold_cnt_n  = hold_cnt;
    timeout_n   = 1'b0;
    last_enc_n  = last_enc;
    grant_cnt_n = grant_cnt;
    case (state)
      IDLE: begin
        if (valid) begin
          state_n     = GRANT;
          last_enc_n  = enc;
          grant_n     = 8'd1 << enc;
          hold_cnt_n  = 8'd0;
          grant_cnt_n = grant_cnt + 8'd1;
        end
      end
      GRANT: begin
        // An explicit release takes priority over the forced-release timeout.
        if (release_i) begin
          state_n = COOLDOWN;
          grant_n = 8'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n   = COOLDOWN;
          grant_n   = 8'd0;
          timeout_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      COOLDOWN: state_n = IDLE;
      default: begin
        state_n = IDLE;
        grant_n = 8'd0;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_grant_decoder.sv
// tb/tb_grant_decoder.sv - randomized and directed self-checking bench for grant_decoder.
module tb_grant_decoder;

  localparam int HOLD_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] enc = 3'd0;
  logic       valid = 1'b0;
  logic       release_i = 1'b0;
  logic       ready, busy, timeout;
  logic [7:0] grant, grant_cnt;
  logic [2:0] last_enc;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1 granting, 2 cooldown; held counts visible grant cycles.
  int         m_phase = 0;
  int         m_held = 0;
  int         m_last = 0;
  int         m_count = 0;
  bit         m_timeout = 0;

  grant_decoder #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .enc(enc), .valid(valid), .ready(ready),
    .release_i(release_i), .grant(grant), .busy(busy), .timeout(timeout),
    .last_enc(last_enc), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (rst || $onehot0(grant)) else $error("FAIL onehot0 grant=%b", grant);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_held = 0; m_last = 0; m_count = 0; m_timeout = 0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        m_timeout = 0;
        if (valid) begin
          m_phase = 1; m_last = int'(enc); m_count = (m_count + 1) % 256; m_held = 1;
        end
      end
      1: begin
        if (release_i) begin
          m_phase = 2; m_timeout = 0;
        end else if (m_held == HOLD_MAX) begin
          m_phase = 2; m_timeout = 1;
        end else m_held++;
      end
      default: begin
        m_phase = 0; m_timeout = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("grant", grant, (m_phase == 1) ? (32'd1 << m_last) : 32'd0);
    check("busy", busy, m_phase == 1);
    check("ready", ready, m_phase == 0);
    check("timeout", timeout, m_timeout);
    check("last_enc", last_enc, m_last);
    check("grant_cnt", grant_cnt, m_count);
    check("onehot0", $onehot0(grant), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", grant_cnt, 0);
    check("rst_ready", ready, 1);
    check("rst_timeout", timeout, 0);
    check("rst_last", last_enc, 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int gc, tc, saved_cnt;
    bit to_seen;
    #2;
    check("init_ready", ready, 1);
    check("init_grant", grant, 0);
    check("init_busy", busy, 0);
    check("init_cnt", grant_cnt, 0);
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Accept enc=5 and release three cycles later.
    enc = 3'd5; valid = 1'b1; step();
    check("acc_grant", grant, 32'h20);
    check("acc_cnt", grant_cnt, 1);
    valid = 1'b0; to_seen = 0;
    step(); step();
    release_i = 1'b1; step();
    release_i = 1'b0;
    check("rel_cool_grant", grant, 0);
    check("rel_cool_ready", ready, 0);
    to_seen = to_seen | timeout;
    step();
    check("rel_idle_ready", ready, 1);
    check("rel_no_timeout", to_seen, 0);

    // Forced release on enc=0.
    enc = 3'd0; valid = 1'b1; step();
    valid = 1'b0; gc = 1; tc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant != 8'd0) gc++;
      if (timeout) tc++;
    end
    check("forced_len", gc, HOLD_MAX);
    check("forced_to_cycles", tc, 1);

    // Release arrives on the edge that would otherwise time out.
    enc = 3'd6; valid = 1'b1; step();
    valid = 1'b0;
    for (int i = 0; i < HOLD_MAX - 1; i++) step();
    check("tie_still_granted", grant, 32'h40);
    release_i = 1'b1; step();
    release_i = 1'b0;
    check("tie_timeout", timeout, 0);
    check("tie_cool", ready | busy, 0);
    step();

    // valid/enc during GRANT are ignored.
    enc = 3'd2; valid = 1'b1; step();
    saved_cnt = int'(grant_cnt);
    enc = 3'd7;
    for (int i = 0; i < 5; i++) step();
    check("ign_grant", grant, 32'h04);
    check("ign_last", last_enc, 2);
    check("ign_cnt", grant_cnt, saved_cnt);
    valid = 1'b0; release_i = 1'b1; step();
    release_i = 1'b0; step();

    // Async reset mid-grant, then normal acceptance.
    enc = 3'd3; valid = 1'b1; step();
    valid = 1'b0; step();
    pulse_reset();
    enc = 3'd1; valid = 1'b1; step();
    check("post_rst_grant", grant, 32'h02);
    valid = 1'b0; release_i = 1'b1; step();
    release_i = 1'b0; step();

    // 256 back-to-back accept/release sequences wrap the counter.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      enc = 3'($urandom_range(0, 7)); valid = 1'b1; step();
      valid = 1'b0; release_i = 1'b1; step();
      release_i = 1'b0; step();
    end
    check("wrap_cnt", grant_cnt, 0);

    // Randomized traffic with varying release probability.
    for (int blk = 0; blk < 8; blk++) begin
      int rel_pct;
      rel_pct = (blk % 4 == 0) ? 0 : int'($urandom_range(5, 60));
      for (int i = 0; i < 250; i++) begin
        enc = 3'($urandom_range(0, 7));
        valid = ($urandom_range(0, 99) < 50);
        release_i = (int'($urandom_range(0, 99)) < rel_pct);
        step();
      end
    end
    valid = 1'b0; release_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
